// File: rtl/simd_issue_ctrl.sv
// ---------------------------------------------------------------------------
// simd_issue_ctrl
//
// Instruction sequencer at the front of the pipelined multimedia SIMD unit.
// A small program buffer is loaded from the host port while the sequencer is
// idle. On start it issues one instruction per cycle into the IF/ID stage
// register. After the last program instruction it issues DRAIN_CYCLES NOPs
// so the downstream stages empty, then reports completion. A hold input
// stalls issue for a cycle without losing or skipping an instruction.
//
// Handshake / control semantics: load_en and start are single-cycle
// qualifiers sampled on the rising edge of clk. They are accepted only while
// the sequencer is IDLE or DONE and are silently ignored while busy. There is
// no back-pressure on the output side: instr_out/instr_valid are registered
// and change every cycle; instr_valid=1 marks a real program instruction,
// instr_valid=0 marks a filler NOP.
//
// Ports:
//   clk          in   1     rising-edge clock
//   rst          in   1     synchronous, active-high reset
//   load_en      in   1     write load_instr into buffer[load_addr]
//   load_addr    in   AW    buffer write address
//   load_instr   in   25    instruction word to store
//   prog_len     in   AW+1  number of instructions to run (latched on start)
//   start        in   1     begin program execution
//   hold         in   1     stall issue for this cycle
//   instr_out    out  25    instruction presented to the IF/ID register
//   instr_valid  out  1     instr_out is a real program instruction
//   pc           out  AW    index of the next buffer entry to issue
//   issued_count out  AW+1  program instructions issued since last start
//   busy         out  1     state is RUN or DRAIN
//   done         out  1     state is DONE
// ---------------------------------------------------------------------------
module simd_issue_ctrl #(
    parameter int          DEPTH        = 64,
    parameter int          AW           = 6,
    parameter int          DRAIN_CYCLES = 3,
    parameter logic [24:0] NOP          = 25'b1100000000000000000000000
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load_en,
    input  logic [AW-1:0] load_addr,
    input  logic [24:0]   load_instr,
    input  logic [AW:0]   prog_len,
    input  logic          start,
    input  logic          hold,
    output logic [24:0]   instr_out,
    output logic          instr_valid,
    output logic [AW-1:0] pc,
    output logic [AW:0]   issued_count,
    output logic          busy,
    output logic          done
);

    // Drain counter must hold the value DRAIN_CYCLES itself.
    localparam int DW = (DRAIN_CYCLES < 2) ? 1 : $clog2(DRAIN_CYCLES + 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] pc_q, pc_d;
    logic [AW:0]   issued_q, issued_d;
    logic [AW:0]   len_q, len_d;
    logic [DW-1:0] drain_q, drain_d;
    logic [24:0]   instr_q, instr_d;
    logic          valid_q, valid_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;

    // Program buffer; deliberately not reset.
    logic [24:0]   prog_mem_q [DEPTH];

    logic          can_accept;
    logic          start_ok;
    logic [AW:0]   len_clamped;
    logic          last_issue;

    assign can_accept  = (state_q == S_IDLE) || (state_q == S_DONE);
    assign start_ok    = start && can_accept;
    assign len_clamped = (prog_len > (AW+1)'(DEPTH)) ? (AW+1)'(DEPTH) : prog_len;
    // The issue happening this cycle is the final one of the program.
    assign last_issue  = ((issued_q + (AW+1)'(1)) == len_q);

    // -----------------------------------------------------------------------
    // Program buffer write port. A load sampled together with start is
    // written at that same edge, so the first issue (one edge later) already
    // reads the new word -- no bypass path is needed.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (load_en && can_accept) begin
            prog_mem_q[load_addr] <= load_instr;
        end
    end

    // -----------------------------------------------------------------------
    // State and output registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            pc_q     <= '0;
            issued_q <= '0;
            len_q    <= '0;
            drain_q  <= '0;
            instr_q  <= NOP;
            valid_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            issued_q <= issued_d;
            len_q    <= len_d;
            drain_q  <= drain_d;
            instr_q  <= instr_d;
            valid_q  <= valid_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    // An empty program still drains so done timing is uniform.
                    state_d = (len_clamped != '0) ? S_RUN : S_DRAIN;
                end
            end
            S_RUN: begin
                if (!hold && last_issue) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                // Leave only once the counter has already reached zero, i.e.
                // after DRAIN_CYCLES NOP issues have been counted down.
                if (drain_q == '0) begin
                    state_d = S_DONE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // -----------------------------------------------------------------------
    // Output / datapath next values
    // -----------------------------------------------------------------------
    always_comb begin
        pc_d     = pc_q;
        issued_d = issued_q;
        len_d    = len_q;
        drain_d  = drain_q;
        instr_d  = NOP;
        valid_d  = 1'b0;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start_ok) begin
                    len_d    = len_clamped;
                    pc_d     = '0;
                    issued_d = '0;
                    drain_d  = DW'(DRAIN_CYCLES);
                end
            end
            S_RUN: begin
                if (!hold) begin
                    instr_d  = prog_mem_q[pc_q];
                    valid_d  = 1'b1;
                    issued_d = issued_q + (AW+1)'(1);
                    if (last_issue) begin
                        // pc stays on the final entry; only a full-depth
                        // program would otherwise wrap it back to 0.
                        drain_d = DW'(DRAIN_CYCLES);
                    end else begin
                        pc_d = pc_q + AW'(1);
                    end
                end
            end
            S_DRAIN: begin
                if (drain_q != '0) begin
                    drain_d = drain_q - DW'(1);
                end
            end
            default: begin
            end
        endcase

        busy_d = (state_d == S_RUN) || (state_d == S_DRAIN);
        done_d = (state_d == S_DONE);
    end

    assign instr_out    = instr_q;
    assign instr_valid  = valid_q;
    assign pc           = pc_q;
    assign issued_count = issued_q;
    assign busy         = busy_q;
    assign done         = done_q;

    // -----------------------------------------------------------------------
    // Invariants
    // -----------------------------------------------------------------------
    a_busy_done_excl : assert property (@(posedge clk) !(busy_q && done_q));
    a_valid_in_busy  : assert property (@(posedge clk) disable iff (rst)
                                        valid_q |-> busy_q);
    a_issued_le_len  : assert property (@(posedge clk) disable iff (rst)
                                        issued_q <= len_q);

endmodule

// File: tb/tb_simd_issue_ctrl.sv
module tb_simd_issue_ctrl;

    localparam int          DEPTH = 64;
    localparam int          AW    = 6;
    localparam int          DRAIN = 3;
    localparam logic [24:0] NOP_W = 25'h1800000;

    // ---------------- clock / reset ----------------
    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          load_en = 1'b0;
    logic [AW-1:0] load_addr = '0;
    logic [24:0]   load_instr = '0;
    logic [AW:0]   prog_len = '0;
    logic          start = 1'b0;
    logic          hold = 1'b0;
    logic [24:0]   instr_out;
    logic          instr_valid;
    logic [AW-1:0] pc;
    logic [AW:0]   issued_count;
    logic          busy;
    logic          done;

    always #5 clk = ~clk;

    simd_issue_ctrl #(
        .DEPTH(DEPTH), .AW(AW), .DRAIN_CYCLES(DRAIN), .NOP(NOP_W)
    ) dut (
        .clk(clk), .rst(rst), .load_en(load_en), .load_addr(load_addr),
        .load_instr(load_instr), .prog_len(prog_len), .start(start),
        .hold(hold), .instr_out(instr_out), .instr_valid(instr_valid),
        .pc(pc), .issued_count(issued_count), .busy(busy), .done(done)
    );

    // ---------------- scoreboard ----------------
    logic [25:0] exp_q[$];          // {instr_valid, instr_out} per cycle
    logic [24:0] model_mem [DEPTH];
    int          tests_run = 0;
    int          tests_failed = 0;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    // ---------------- driver tasks ----------------
    // All tasks start and end 1 time unit after a rising edge.
    task automatic load_word(input logic [AW-1:0] a, input logic [24:0] d);
        load_en = 1'b1; load_addr = a; load_instr = d;
        @(posedge clk); #1;
        load_en = 1'b0;
        model_mem[a] = d;
    endtask

    task automatic pulse_start(input logic [AW:0] len);
        prog_len = len; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // Expected output stream of a run: issues honour the hold mask (bit c is
    // hold at the c-th edge after start), then DRAIN filler NOPs.
    task automatic push_expected(input int eff_len, input logic [63:0] hmask);
        int idx = 0;
        int c = 0;
        while (idx < eff_len) begin
            if (hmask[c]) exp_q.push_back({1'b0, NOP_W});
            else begin
                exp_q.push_back({1'b1, model_mem[idx]});
                idx++;
            end
            c++;
        end
        for (int k = 0; k < DRAIN; k++) exp_q.push_back({1'b0, NOP_W});
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        tests_run++;
        if ({instr_valid, instr_out} !== {1'b0, NOP_W}) begin
            tests_failed++;
            $display("FAIL reset_instr: got %b/%h expected 0/%h", instr_valid, instr_out, NOP_W);
        end
        tests_run++;
        if ({busy, done, pc, issued_count} !== '0) begin
            tests_failed++;
            $display("FAIL reset_ctrl: busy=%b done=%b pc=%0d cnt=%0d expected all 0",
                     busy, done, pc, issued_count);
        end
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_basic();
        logic [25:0] e;
        int n;
        load_word(0, 25'h0000001);
        load_word(1, 25'h0800002);
        load_word(2, 25'h1000003);
        load_word(3, 25'h1800004);
        push_expected(4, '0);
        pulse_start(4);
        n = exp_q.size();
        for (int c = 0; c < n; c++) begin
            @(posedge clk); #1;
            e = exp_q.pop_front();
            tests_run++;
            if ({instr_valid, instr_out} !== e || busy !== 1'b1 || done !== 1'b0) begin
                tests_failed++;
                $display("FAIL basic_stream[%0d]: got %b/%h busy=%b done=%b expected %b/%h busy=1 done=0",
                         c, instr_valid, instr_out, busy, done, e[25], e[24:0]);
            end
        end
        @(posedge clk); #1;
        tests_run++;
        if ({done, busy, issued_count, pc} !== {1'b1, 1'b0, 7'd4, 6'd3}) begin
            tests_failed++;
            $display("FAIL basic_done: done=%b busy=%b cnt=%0d pc=%0d expected 1 0 4 3",
                     done, busy, issued_count, pc);
        end
    endtask

    task automatic test_hold();
        logic [25:0] e;
        logic [63:0] hmask = 64'b0110;   // hold at edges N+2 and N+3
        logic [AW-1:0] exp_pc = '0;
        int n;
        push_expected(4, hmask);
        pulse_start(4);
        n = exp_q.size();
        for (int c = 0; c < n; c++) begin
            hold = hmask[c];
            @(posedge clk); #1;
            e = exp_q.pop_front();
            if (e[25] && exp_pc != 6'd3) exp_pc++;
            tests_run++;
            if ({instr_valid, instr_out} !== e || pc !== exp_pc) begin
                tests_failed++;
                $display("FAIL hold_stream[%0d]: got %b/%h pc=%0d expected %b/%h pc=%0d",
                         c, instr_valid, instr_out, pc, e[25], e[24:0], exp_pc);
            end
        end
        hold = 1'b0;
        // Stream covers N+1..N+9; done expected at N+10.
        @(posedge clk); #1;
        tests_run++;
        if (done !== 1'b1 || issued_count !== 7'd4) begin
            tests_failed++;
            $display("FAIL hold_done: done=%b cnt=%0d expected 1 4", done, issued_count);
        end
    endtask

    task automatic test_ignore_while_busy();
        logic [25:0] e;
        int n;
        push_expected(4, '0);
        pulse_start(4);
        n = exp_q.size();
        for (int c = 0; c < n; c++) begin
            if (c == 1 || c == 5) begin
                start = 1'b1; load_en = 1'b1; load_addr = '0; load_instr = 25'h1ABCDEF;
            end else begin
                start = 1'b0; load_en = 1'b0;
            end
            @(posedge clk); #1;
            e = exp_q.pop_front();
            tests_run++;
            if ({instr_valid, instr_out} !== e) begin
                tests_failed++;
                $display("FAIL ignore_stream[%0d]: got %b/%h expected %b/%h",
                         c, instr_valid, instr_out, e[25], e[24:0]);
            end
        end
        start = 1'b0; load_en = 1'b0;
        @(posedge clk); #1;
        tests_run++;
        if (done !== 1'b1) begin
            tests_failed++;
            $display("FAIL ignore_done: done=%b expected 1", done);
        end
        // Rerun: start accepted from DONE clears done, buf[0] unchanged.
        pulse_start(4);
        tests_run++;
        if ({busy, done, issued_count} !== {1'b1, 1'b0, 7'd0}) begin
            tests_failed++;
            $display("FAIL rerun_accept: busy=%b done=%b cnt=%0d expected 1 0 0", busy, done, issued_count);
        end
        @(posedge clk); #1;
        tests_run++;
        if ({instr_valid, instr_out} !== {1'b1, model_mem[0]}) begin
            tests_failed++;
            $display("FAIL rerun_word0: got %b/%h expected 1/%h", instr_valid, instr_out, model_mem[0]);
        end
        repeat (7) @(posedge clk);
        #1;
        tests_run++;
        if (done !== 1'b1) begin
            tests_failed++;
            $display("FAIL rerun_done: done=%b expected 1", done);
        end
    endtask

    task automatic test_same_cycle_load_start();
        logic [25:0] e;
        int n;
        // Load to address 0 sampled at the same edge as start.
        load_en = 1'b1; load_addr = '0; load_instr = 25'h0F0F0F0;
        model_mem[0] = 25'h0F0F0F0;
        push_expected(2, '0);
        pulse_start(2);
        load_en = 1'b0;
        n = exp_q.size();
        for (int c = 0; c < n; c++) begin
            @(posedge clk); #1;
            e = exp_q.pop_front();
            tests_run++;
            if ({instr_valid, instr_out} !== e) begin
                tests_failed++;
                $display("FAIL samecyc_stream[%0d]: got %b/%h expected %b/%h",
                         c, instr_valid, instr_out, e[25], e[24:0]);
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_zero_len();
        bit saw_valid = 0;
        bit saw_done = 0;
        pulse_start(0);
        for (int c = 0; c < 12 && !saw_done; c++) begin
            @(posedge clk); #1;
            if (instr_valid) saw_valid = 1;
            if (c < 2) begin
                tests_run++;
                if (busy !== 1'b1 || done !== 1'b0) begin
                    tests_failed++;
                    $display("FAIL zero_drain[%0d]: busy=%b done=%b expected 1 0", c, busy, done);
                end
            end
            if (done) saw_done = 1;
        end
        tests_run++;
        if (saw_valid || !saw_done || issued_count !== '0) begin
            tests_failed++;
            $display("FAIL zero_len: saw_valid=%b saw_done=%b cnt=%0d expected 0 1 0",
                     saw_valid, saw_done, issued_count);
        end
    endtask

    task automatic test_clamp();
        logic [25:0] e;
        int n;
        int errs = 0;
        for (int a = 0; a < DEPTH; a++)
            load_word(AW'(a), 25'($urandom_range(0, 33554431)));
        push_expected(DEPTH, '0);
        pulse_start(7'd100);
        n = exp_q.size();
        for (int c = 0; c < n; c++) begin
            @(posedge clk); #1;
            e = exp_q.pop_front();
            tests_run++;
            if ({instr_valid, instr_out} !== e) begin
                tests_failed++;
                errs++;
                if (errs < 5)
                    $display("FAIL clamp_stream[%0d]: got %b/%h expected %b/%h",
                             c, instr_valid, instr_out, e[25], e[24:0]);
            end
        end
        @(posedge clk); #1;
        tests_run++;
        if ({done, issued_count, pc} !== {1'b1, 7'd64, 6'd63}) begin
            tests_failed++;
            $display("FAIL clamp_done: done=%b cnt=%0d pc=%0d expected 1 64 63", done, issued_count, pc);
        end
    endtask

    task automatic test_reset_mid_run();
        logic [25:0] e;
        int n;
        load_word(0, 25'h0000001);
        load_word(1, 25'h0800002);
        load_word(2, 25'h1000003);
        load_word(3, 25'h1800004);
        push_expected(4, '0);
        pulse_start(4);
        for (int c = 0; c < 2; c++) begin
            @(posedge clk); #1;
            e = exp_q.pop_front();
            tests_run++;
            if ({instr_valid, instr_out} !== e) begin
                tests_failed++;
                $display("FAIL abort_pre[%0d]: got %b/%h expected %b/%h",
                         c, instr_valid, instr_out, e[25], e[24:0]);
            end
        end
        exp_q.delete();
        rst = 1'b1;                      // sampled at the third issue edge
        @(posedge clk); #1;
        rst = 1'b0;
        tests_run++;
        if ({instr_valid, instr_out, busy, done, pc} !== {1'b0, NOP_W, 1'b0, 1'b0, 6'd0}) begin
            tests_failed++;
            $display("FAIL abort_state: got v=%b %h busy=%b done=%b pc=%0d expected 0 %h 0 0 0",
                     instr_valid, instr_out, busy, done, pc, NOP_W);
        end
        push_expected(4, '0);
        pulse_start(4);
        n = exp_q.size();
        for (int c = 0; c < n; c++) begin
            @(posedge clk); #1;
            e = exp_q.pop_front();
            tests_run++;
            if ({instr_valid, instr_out} !== e) begin
                tests_failed++;
                $display("FAIL abort_rerun[%0d]: got %b/%h expected %b/%h",
                         c, instr_valid, instr_out, e[25], e[24:0]);
            end
        end
        @(posedge clk); #1;
        tests_run++;
        if (done !== 1'b1 || issued_count !== 7'd4) begin
            tests_failed++;
            $display("FAIL abort_done: done=%b cnt=%0d expected 1 4", done, issued_count);
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        @(posedge clk); #1;
        test_reset();
        test_basic();
        test_hold();
        test_ignore_while_busy();
        test_same_cycle_load_start();
        test_zero_len();
        test_clamp();
        test_reset_mid_run();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/simd_issue_ctrl.md
Name: simd_issue_ctrl

Overview:
- Instruction sequencer at the front of the pipelined multimedia SIMD unit.
- Holds a small program buffer of 25-bit SIMD instructions, loaded from the testbench or host port.
- On start, issues one instruction per cycle into the IF/ID stage register.
- After the last instruction it injects NOPs to drain the pipeline, then signals completion.
- Supports a hold (stall) input that freezes issue without losing instructions.

Parameters:
- DEPTH, 64: program buffer entries; must be a power of two.
- AW, 6: buffer address width, equal to log2(DEPTH).
- DRAIN_CYCLES, 3: NOP cycles issued after the last instruction (IF/ID, ID/EX, EX/WB).
- NOP, 25'b1100000000000000000000000: no-write instruction encoding.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- load_en  in  1  write load_instr into buffer[load_addr].
- load_addr  in  AW  buffer write address.
- load_instr  in  25  instruction word to store.
- prog_len  in  AW+1  number of instructions to run; latched when start is accepted.
- start  in  1  begin program execution.
- hold  in  1  stall issue for this cycle.
- instr_out  out  25  instruction presented to the IF/ID register.
- instr_valid  out  1  instr_out is a real program instruction, not a filler NOP.
- pc  out  AW  index of the next buffer entry to issue.
- issued_count  out  AW+1  program instructions issued since the last start.
- busy  out  1  state is RUN or DRAIN.
- done  out  1  state is DONE.

Behaviour:
- All outputs are registered. On rst (synchronous): state=IDLE, pc=0, instr_out=NOP, instr_valid=0, issued_count=0, busy=0, done=0, drain counter=0.
- rst mid-RUN or mid-DRAIN aborts the program; instr_out is NOP from the following cycle.
- Buffer contents are not reset.
- States: IDLE, RUN, DRAIN, DONE.
- Loading: load_en is accepted only in IDLE or DONE; ignored in RUN and DRAIN. A load is written at the clock edge where it is sampled.
- Start: accepted only in IDLE or DONE; ignored while busy.
  - On acceptance: latch len = min(prog_len, DEPTH); pc=0; issued_count=0; done=0.
  - Next state is RUN if len>0, otherwise DRAIN.
- Same-cycle load_en and start in IDLE: both take effect. The written word is visible to the first issue, including address 0.
- RUN, each edge with hold=0:
  - instr_out <= buf[pc]; instr_valid <= 1; issued_count++.
  - If issued_count+1 == len, go to DRAIN and load the drain counter with DRAIN_CYCLES; otherwise pc++.
- RUN, each edge with hold=1: instr_out <= NOP; instr_valid <= 0; pc and issued_count unchanged.
- Latency: start sampled at edge N gives buf[0] on instr_out after edge N+1 (with hold=0 at N+1).
- pc wraps modulo DEPTH (only reachable when len==DEPTH); at the final issue pc is not incremented.
- DRAIN: instr_out <= NOP; instr_valid <= 0; hold is ignored. The drain counter decrements each edge. When it reaches 0 after DRAIN_CYCLES NOP cycles, go to DONE.
- DONE: busy=0, done=1; instr_out=NOP. done stays asserted until the next accepted start or rst.
- busy and done are never both 1.
- prog_len > DEPTH is clamped to DEPTH.

Test Plan:
- Reset then load buf[0..3] = 25'h0000001, 25'h0800002, 25'h1000003, 25'h1800004; prog_len=4; pulse start at edge N.
  -> instr_out shows those four words at edges N+1..N+4 with instr_valid=1.
  -> NOP with instr_valid=0 at edges N+5..N+7.
  -> done=1 from edge N+8; issued_count=4.
- Same program with hold=1 at edges N+2 and N+3.
  -> NOP with instr_valid=0 in those cycles; word 2 issues at N+4; done=1 at N+10; pc never skips an entry.
- start pulsed during RUN, and load_en to address 0 during RUN.
  -> Both ignored; program completes unchanged; buf[0] keeps its old value on a rerun.
- prog_len=0 start -> instr_valid never 1; done=1 after 3 DRAIN cycles. prog_len=100 with DEPTH=64 -> exactly 64 issues, issued_count=64.
- rst asserted at the third RUN issue.
  -> Next cycle: instr_out=NOP, busy=0, done=0, pc=0.
  -> A new start then re-runs from buf[0].
